matrix_instr_exec: RTL

MATRIX_INSTR_EXEC -- requirements
Module: matrix_instr_exec

---
 rtl/matrix_instr_exec.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_instr_exec.sv
// matrix_instr_exec: small matrix coprocessor holding three DATA_W-bit
// MAX_DIM x MAX_DIM matrices (A, B, C). Executes STORE, LOAD and
// element-wise ADD (C = A + B over an N x N top-left window) from a
// 22-bit instruction word accepted on a rising edge of start.
module matrix_instr_exec #(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [21:0]       instr,
  input  logic              start,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf
);

  localparam logic [2:0] DIM_L = 3'(MAX_DIM);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_STORE, S_LOAD, S_ADD_RUN, S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                     r_start;
  logic [21:0]              r_instr;
  logic                     w_accept;

  logic signed [DATA_W-1:0] r_mem_a [MAX_DIM][MAX_DIM];
  logic signed [DATA_W-1:0] r_mem_b [MAX_DIM][MAX_DIM];
  logic signed [DATA_W-1:0] r_mem_c [MAX_DIM][MAX_DIM];

  logic [1:0]               w_op;
  logic [7:0]               w_data;
  logic [1:0]               w_mat;
  logic [2:0]               w_row;
  logic [2:0]               w_col;
  logic [2:0]               w_n;
  logic                     w_in_range;
  logic                     w_legal;
  logic [DATA_W-1:0]        w_ld_val;
  logic                     w_finish;

  // ADD element walk: row/col issue counters and a one-cycle drain flag
  logic [2:0]               r_ar;
  logic [2:0]               r_ac;
  logic                     r_drain;

  logic signed [DATA_W-1:0] r_sum_p0;
  logic [2:0]               r_row_p0;
  logic [2:0]               r_col_p0;
  logic                     r_ovf_p0;
  logic                     r_vld_p0;

  logic [DATA_W-1:0]        r_result;
  logic                     r_err;
  logic                     r_ovf;

  function automatic logic signed [DATA_W-1:0] add_wrap(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a + b;
  endfunction

  function automatic logic add_ovf(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] s;
    s = a + b;
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  assign w_op     = r_instr[21:20];
  assign w_data   = r_instr[19:12];
  assign w_mat    = r_instr[11:10];
  assign w_row    = r_instr[9:7];
  assign w_col    = r_instr[6:4];
  assign w_accept = start && !r_start && (r_state == S_IDLE);
  assign w_finish = (r_state == S_STORE) || (r_state == S_LOAD) ||
                    ((r_state == S_ADD_RUN) && r_drain);

  // Decode the latched instruction: ADD window size, legality, LOAD read mux
  always_comb begin
    w_n        = r_instr[2:0];
    if ((r_instr[2:0] == 3'd0) || (r_instr[2:0] > DIM_L)) begin
      w_n = DIM_L;
    end
    w_in_range = (w_row < DIM_L) && (w_col < DIM_L);
    w_legal    = 1'b0;
    case (w_op)
      OP_STORE: w_legal = w_in_range && ((w_mat == 2'b00) || (w_mat == 2'b01));
      OP_LOAD:  w_legal = w_in_range && (w_mat != 2'b11);
      OP_ADD:   w_legal = 1'b1;
      default:  w_legal = 1'b0;
    endcase
    w_ld_val = '0;
    if (w_in_range) begin
      case (w_mat)
        2'b00:   w_ld_val = r_mem_a[w_row][w_col];
        2'b01:   w_ld_val = r_mem_b[w_row][w_col];
        2'b10:   w_ld_val = r_mem_c[w_row][w_col];
        default: w_ld_val = '0;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; illegal non-ADD ops pass through STORE doing nothing
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_op == OP_ADD)       w_state_nxt = S_ADD_RUN;
        else if (w_op == OP_LOAD) w_state_nxt = S_LOAD;
        else                      w_state_nxt = S_STORE;
      end
      S_STORE:   w_state_nxt = S_DONE;
      S_LOAD:    w_state_nxt = S_DONE;
      S_ADD_RUN: if (r_drain) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Instruction latch at acceptance; later instr changes are ignored
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_instr <= instr;
    end
  end

  // Control: start edge detect, ADD walk counters, status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start  <= 1'b0;
      r_ar     <= '0;
      r_ac     <= '0;
      r_drain  <= 1'b0;
      r_vld_p0 <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_start  <= start;
      r_vld_p0 <= (r_state == S_ADD_RUN) && !r_drain;
      if (w_accept) begin
        r_ar    <= '0;
        r_ac    <= '0;
        r_drain <= 1'b0;
        if (instr[21:20] == OP_ADD) begin
          r_ovf <= 1'b0;
        end
      end else if (r_vld_p0 && r_ovf_p0) begin
        r_ovf <= 1'b1;
      end
      if ((r_state == S_ADD_RUN) && !r_drain) begin
        if (r_ac == w_n - 3'd1) begin
          r_ac <= '0;
          if (r_ar == w_n - 3'd1) begin
            r_drain <= 1'b1;
          end else begin
            r_ar <= r_ar + 3'd1;
          end
        end else begin
          r_ac <= r_ac + 3'd1;
        end
      end
      if (w_finish) begin
        r_err <= !w_legal;
        if ((r_state == S_LOAD) && w_legal) begin
          r_result <= w_ld_val;
        end
      end
    end
  end

  // Stage p0: operand fetch and wrapped sum for the element being issued
  always_ff @(posedge clk) begin
    r_sum_p0 <= add_wrap(r_mem_a[r_ar][r_ac], r_mem_b[r_ar][r_ac]);
    r_ovf_p0 <= add_ovf(r_mem_a[r_ar][r_ac], r_mem_b[r_ar][r_ac]);
    r_row_p0 <= r_ar;
    r_col_p0 <= r_ac;
  end

  // Stage p1: matrix storage; STORE writes A/B, the ADD pipeline writes C
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MAX_DIM; r++) begin
        for (int c = 0; c < MAX_DIM; c++) begin
          r_mem_a[r][c] <= '0;
          r_mem_b[r][c] <= '0;
          r_mem_c[r][c] <= '0;
        end
      end
    end else begin
      if ((r_state == S_STORE) && w_legal) begin
        if (w_mat == 2'b00) begin
          r_mem_a[w_row][w_col] <= DATA_W'(w_data);
        end else begin
          r_mem_b[w_row][w_col] <= DATA_W'(w_data);
        end
      end
      if (r_vld_p0) begin
        r_mem_c[r_row_p0][r_col_p0] <= r_sum_p0;
      end
    end
  end

  assign result = r_result;
  assign err    = r_err;
  assign ovf    = r_ovf;

endmodule
